// File: rtl/led7219_pkg.sv
// Shared constants for the MAX7219-style serial receiver: frame width,
// register address map and the digit-row placement rule.
package led7219_pkg;

   localparam int FRAME_W = 16;
   localparam int CNT_W   = 7;

   typedef enum logic [3:0] {
      REG_NOOP      = 4'h0,
      REG_DIGIT0    = 4'h1,
      REG_DIGIT1    = 4'h2,
      REG_DIGIT2    = 4'h3,
      REG_DIGIT3    = 4'h4,
      REG_DIGIT4    = 4'h5,
      REG_DIGIT5    = 4'h6,
      REG_DIGIT6    = 4'h7,
      REG_DIGIT7    = 4'h8,
      REG_DECODE    = 4'h9,
      REG_INTENSITY = 4'hA,
      REG_SCAN      = 4'hB,
      REG_SHUTDOWN  = 4'hC,
      REG_TEST      = 4'hF
   } reg_addr_e;

   // Row 1 of the farthest device occupies the top byte of the image.
   function automatic int digit_base(input int row, input int dev, input int n_dev);
      return 64 * n_dev - 8 * n_dev * row + 8 * dev;
   endfunction

endpackage

// File: rtl/led_sync.sv
// Two-flop synchronizer plus an edge-detect register for one serial input.
// Edges are only reported once the whole pipeline holds real samples.
module led_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic       r_meta;
   logic       r_sync;
   logic       r_prev;
   logic [2:0] r_fill;

   // NOTE: non-blocking assignments make the three flops a true pipeline;
   // blocking ones would collapse it into a single stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
         r_prev <= RST_VAL;
         r_fill <= '0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_fill <= {r_fill[1:0], 1'b1};
      end
   end

   // NOTE: the reset values are not real samples; without the fill mask a
   // line held low across reset would look like a falling edge afterwards.
   assign o_level = r_sync;
   assign o_rise  = r_fill[2] &  r_sync & ~r_prev;
   assign o_fall  = r_fill[2] & ~r_sync &  r_prev;

endmodule

// File: rtl/led7219_rx.sv
// Far-end receiver for a chain of MAX7219-style LED drivers: shifts the
// serial frame in and mirrors each device's register file on parallel outputs.
module led7219_rx
   import led7219_pkg::*;
#(
   parameter int N_DEV = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 leds_in,
   input  logic                 leds_clk_in,
   input  logic                 leds_cs_in,
   output logic [64*N_DEV-1:0]  image,
   output logic [4*N_DEV-1:0]   intensity,
   output logic [3*N_DEV-1:0]   scan_limit,
   output logic [8*N_DEV-1:0]   decode_mode,
   output logic [N_DEV-1:0]     shutdown_n,
   output logic [N_DEV-1:0]     test,
   output logic                 update,
   output logic                 frame_err,
   output logic                 leds_out
);

   localparam int                SR_W       = FRAME_W * N_DEV;
   localparam logic [CNT_W-1:0]  FRAME_BITS = CNT_W'(SR_W);

   logic w_din, w_din_rise, w_din_fall;
   logic w_sclk, w_sclk_rise, w_sclk_fall;
   logic w_cs, w_cs_rise, w_cs_fall;
   logic w_unused;

   led_sync #(.RST_VAL(1'b0)) u_sync_din (
      .clk(clk), .rst(rst), .i_async(leds_in),
      .o_level(w_din), .o_rise(w_din_rise), .o_fall(w_din_fall));

   led_sync #(.RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .i_async(leds_clk_in),
      .o_level(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

   led_sync #(.RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .i_async(leds_cs_in),
      .o_level(w_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

   assign w_unused = ^{w_din_rise, w_din_fall, w_sclk, w_sclk_fall};

   logic                 r_armed;
   logic [CNT_W-1:0]     r_bit_cnt;
   logic [SR_W-1:0]      r_sr;
   logic [64*N_DEV-1:0]  r_image;
   logic [4*N_DEV-1:0]   r_intensity;
   logic [3*N_DEV-1:0]   r_scan_limit;
   logic [8*N_DEV-1:0]   r_decode_mode;
   logic [N_DEV-1:0]     r_shutdown_n;
   logic [N_DEV-1:0]     r_test;
   logic                 r_update;
   logic                 r_frame_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_armed       <= 1'b0;
         r_bit_cnt     <= '0;
         r_sr          <= '0;
         r_image       <= '0;
         r_intensity   <= '0;
         r_scan_limit  <= '0;
         r_decode_mode <= '0;
         r_shutdown_n  <= '0;
         r_test        <= '0;
         r_update      <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_update    <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_cs_fall) begin
            r_armed   <= 1'b1;
            r_bit_cnt <= '0;
         end else if (w_cs_rise && r_armed) begin
            // CS rise takes priority over a coincident shift clock edge.
            r_armed <= 1'b0;
            if (r_bit_cnt == FRAME_BITS) begin
               r_update <= 1'b1;
               for (int k = 0; k < N_DEV; k++) begin
                  case (r_sr[FRAME_W*k+8 +: 4])
                     REG_DIGIT0, REG_DIGIT1, REG_DIGIT2, REG_DIGIT3,
                     REG_DIGIT4, REG_DIGIT5, REG_DIGIT6, REG_DIGIT7:
                        r_image[digit_base(int'(r_sr[FRAME_W*k+8 +: 4]), k, N_DEV) +: 8]
                           <= r_sr[FRAME_W*k +: 8];
                     REG_DECODE:    r_decode_mode[8*k +: 8] <= r_sr[FRAME_W*k +: 8];
                     REG_INTENSITY: r_intensity[4*k +: 4]   <= r_sr[FRAME_W*k +: 4];
                     REG_SCAN:      r_scan_limit[3*k +: 3]  <= r_sr[FRAME_W*k +: 3];
                     REG_SHUTDOWN:  r_shutdown_n[k]         <= r_sr[FRAME_W*k];
                     REG_TEST:      r_test[k]               <= r_sr[FRAME_W*k];
                     default: ;
                  endcase
               end
            end else begin
               r_frame_err <= 1'b1;
            end
         end else if (w_sclk_rise && r_armed && !w_cs) begin
            r_sr <= {r_sr[SR_W-2:0], w_din};
            if (r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
         end
      end
   end

   assign image       = r_image;
   assign intensity   = r_intensity;
   assign scan_limit  = r_scan_limit;
   assign decode_mode = r_decode_mode;
   assign shutdown_n  = r_shutdown_n;
   assign test        = r_test;
   assign update      = r_update;
   assign frame_err   = r_frame_err;
   assign leds_out    = r_sr[SR_W-1];

endmodule

// File: tb/tb_led7219_rx.sv
// Directed bench for led7219_rx: a per-device register-file model is compared
// against the DUT outputs every quiet cycle, plus literal spot checks.
module tb_led7219_rx;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          leds_in;
   logic          leds_clk_in;
   logic          leds_cs_in;
   logic [255:0]  image;
   logic [15:0]   intensity;
   logic [11:0]   scan_limit;
   logic [31:0]   decode_mode;
   logic [3:0]    shutdown_n;
   logic [3:0]    test;
   logic          update;
   logic          frame_err;
   logic          leds_out;

   always #5 clk = ~clk;

   led7219_rx #(.N_DEV(N)) dut (
      .clk(clk), .rst(rst), .leds_in(leds_in), .leds_clk_in(leds_clk_in),
      .leds_cs_in(leds_cs_in), .image(image), .intensity(intensity),
      .scan_limit(scan_limit), .decode_mode(decode_mode), .shutdown_n(shutdown_n),
      .test(test), .update(update), .frame_err(frame_err), .leds_out(leds_out));

   // Model: each device is a 16-entry byte register file indexed by address.
   logic [7:0] m_reg [N][16];
   int  n_checks = 0;
   int  n_pass   = 0;
   int  upd_cnt  = 0;
   int  err_cnt  = 0;
   bit  chk_en   = 1'b0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic m_reset();
      for (int k = 0; k < N; k++)
         for (int a = 0; a < 16; a++) m_reg[k][a] = 8'h00;
   endtask

   task automatic m_apply(input logic [63:0] data);
      logic [15:0] f;
      for (int k = 0; k < N; k++) begin
         f = data[16*k +: 16];
         m_reg[k][f[11:8]] = f[7:0];
      end
   endtask

   // Image = rows 1..8 in order, each row listing devices far-to-near.
   function automatic logic [255:0] m_image();
      logic [255:0] img = '0;
      for (int r = 1; r <= 8; r++)
         for (int k = N - 1; k >= 0; k--) img = {img[247:0], m_reg[k][r]};
      return img;
   endfunction

   function automatic logic [15:0] m_intensity();
      logic [15:0] v = '0;
      for (int k = 0; k < N; k++) v[4*k +: 4] = m_reg[k][10][3:0];
      return v;
   endfunction

   function automatic logic [11:0] m_scan();
      logic [11:0] v = '0;
      for (int k = 0; k < N; k++) v[3*k +: 3] = m_reg[k][11][2:0];
      return v;
   endfunction

   function automatic logic [31:0] m_decode();
      logic [31:0] v = '0;
      for (int k = 0; k < N; k++) v[8*k +: 8] = m_reg[k][9];
      return v;
   endfunction

   function automatic logic [3:0] m_bit(input int addr);
      logic [3:0] v = '0;
      for (int k = 0; k < N; k++) v[k] = m_reg[k][addr][0];
      return v;
   endfunction

   always @(negedge clk) begin
      if (update)    upd_cnt++;
      if (frame_err) err_cnt++;
      if (chk_en) begin
         check("image",       image,       m_image());
         check("intensity",   intensity,   m_intensity());
         check("scan_limit",  scan_limit,  m_scan());
         check("decode_mode", decode_mode, m_decode());
         check("shutdown_n",  shutdown_n,  m_bit(12));
         check("test",        test,        m_bit(15));
         check("quiet_pulse", {update, frame_err}, '0);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Sends nbits bits (leading zeros pad frames longer than 64), then raises CS.
   // rst_at >= 0 pulses reset just before that bit index.
   task automatic send(input logic [63:0] data, input int nbits, input int rst_at);
      int u0, e0, pad;
      bit was_rst;
      was_rst = 1'b0;
      u0  = upd_cnt;
      e0  = err_cnt;
      pad = (nbits > 64) ? nbits - 64 : 0;
      leds_cs_in = 1'b0;
      wait_cyc(5);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            chk_en = 1'b0;
            rst = 1'b1;
            wait_cyc(1);
            rst = 1'b0;
            m_reset();
            was_rst = 1'b1;
            wait_cyc(1);
            check("rst_image",      image,      '0);
            check("rst_shutdown_n", shutdown_n, '0);
            check("rst_scan_limit", scan_limit, '0);
            chk_en = 1'b1;
            u0 = upd_cnt;
            e0 = err_cnt;
         end
         leds_in = (i < pad) ? 1'b0 : data[63 - (i - pad)];
         wait_cyc(5);
         leds_clk_in = 1'b1;
         wait_cyc(5);
         leds_clk_in = 1'b0;
      end
      wait_cyc(5);
      if (nbits >= 64 && !was_rst) check("leds_out", leds_out, data[63]);
      chk_en = 1'b0;
      leds_cs_in = 1'b1;
      if (nbits == 64 && !was_rst) m_apply(data);
      wait_cyc(10);
      check("update_pulses",    upd_cnt - u0, (nbits == 64 && !was_rst) ? 1 : 0);
      check("frame_err_pulses", err_cnt - e0, (nbits != 64 && !was_rst) ? 1 : 0);
      chk_en = 1'b1;
   endtask

   logic [255:0] pic;
   logic [63:0]  frm;
   int           u_base;

   initial begin
      rst = 1'b1;
      leds_in = 1'b0;
      leds_clk_in = 1'b0;
      leds_cs_in = 1'b1;
      m_reset();
      wait_cyc(3);
      check("reset_image",      image,       '0);
      check("reset_shutdown_n", shutdown_n,  '0);
      check("reset_intensity",  intensity,   '0);
      check("reset_decode",     decode_mode, '0);
      check("reset_pulses",     {update, frame_err, leds_out}, '0);
      rst = 1'b0;
      wait_cyc(5);
      chk_en = 1'b1;

      // Scan-limit broadcast.
      send(64'h0b07_0b07_0b07_0b07, 64, -1);
      check("lit_scan", scan_limit, 12'o7777);
      check("lit_scan_image", image, '0);

      // Single row across the chain.
      send(64'h01A5_015A_01FF_0101, 64, -1);
      check("lit_row1", image, {32'hA55AFF01, 224'h0});

      // Full 12-frame driver sequence.
      u_base = upd_cnt;
      pic = {4{64'h0123456789ABCDEF}};
      send({4{16'h0B07}}, 64, -1);
      send({4{16'h0900}}, 64, -1);
      send({4{16'h0A07}}, 64, -1);
      send({4{16'h0C01}}, 64, -1);
      for (int r = 1; r <= 8; r++) begin
         for (int k = N - 1; k >= 0; k--)
            frm[16*k +: 16] = {4'h0, 4'(r), pic[255 - 32*(r-1) - 8*(N-1-k) -: 8]};
         send(frm, 64, -1);
      end
      check("lit_full_image",     image,      pic);
      check("lit_full_intensity", intensity,  16'h7777);
      check("lit_full_shutdown",  shutdown_n, 4'hF);
      check("lit_full_test",      test,       4'h0);
      check("lit_full_updates",   upd_cnt - u_base, 12);

      // Per-device mixed frame; device 2 receives a no-op.
      send(64'h0c01_0000_0c00_0f01, 64, -1);
      check("lit_mixed_shutdown",  shutdown_n, 4'b1101);
      check("lit_mixed_test",      test,       4'b0001);
      check("lit_mixed_intensity", intensity,  16'h7777);

      // Short, one-bit-long and saturating-length frames are rejected.
      send(64'h0a01_0a01_0a01_0a01, 40, -1);
      check("lit_short_intensity", intensity, 16'h7777);
      send(64'h0a02_0a02_0a02_0a02, 65, -1);
      send(64'h0a02_0a02_0a02_0a02, 130, -1);
      check("lit_long_intensity", intensity, 16'h7777);
      send(64'h0a03_0a03_0a03_0a03, 64, -1);
      check("lit_after_err_intensity", intensity, 16'h3333);

      // Reset in the middle of a frame.
      send(64'h0a0f_0a0f_0a0f_0a0f, 64, 30);
      check("lit_rst_intensity", intensity, 16'h0000);
      send(64'h0b05_0b05_0b05_0b05, 64, -1);
      check("lit_after_rst_scan", scan_limit, 12'o5555);

      chk_en = 1'b0;
      wait_cyc(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/led7219_rx.md
# led7219_rx

- Serial receiver for the MAX7219-style LED chain protocol: 16-bit frames, MSB first, shifted on rising `leds_clk`, latched on rising `leds_cs`, `N_DEV` devices daisy-chained.
- Emulates the register file of each chained device.
- Exposes the reconstructed display image and configuration as parallel outputs, for driving an alternative display and for loop-back checking of the LED driver.
- Sits on the far end of the LED serial link, in the same `clk` domain as the rest of the design.

## Interface
- `N_DEV`, 4, number of chained devices; the frame per latch is 16*`N_DEV` bits.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `leds_in`  in  1  serial data; asynchronous to `clk`.
- `leds_clk_in`  in  1  serial shift clock; asynchronous. High and low phases are each ≥4 `clk` periods.
- `leds_cs_in`  in  1  chip select, active low; its rising edge latches the frame.
- `image`  out  64*`N_DEV`  digit registers; layout below.
- `intensity`  out  4*`N_DEV`  per device k: `[4k+:4]`.
- `scan_limit`  out  3*`N_DEV`  per device k: `[3k+:3]`.
- `decode_mode`  out  8*`N_DEV`  per device k: `[8k+:8]`.
- `shutdown_n`  out  `N_DEV`  1 = normal operation, 0 = shutdown.
- `test`  out  `N_DEV`  display-test bit.
- `update`  out  1  one-cycle pulse when a valid frame is latched.
- `frame_err`  out  1  one-cycle pulse when CS rises after a bit count other than 16*`N_DEV`.
- `leds_out`  out  1  chain pass-through; MSB of the shift register.

## Operation
- **Input synchronization:** each serial input passes through a 2-FF synchronizer, then a third register for edge detection.
- **Armed flag:**
  - Cleared by reset.
  - Set on a synchronized CS falling edge, which also clears the bit counter.
  - While armed and CS is low, each synchronized `leds_clk_in` rising edge shifts `leds_in` into the LSB of the 64*`N_DEV`/4-bit... i.e. the 16*`N_DEV`-bit shift register `sr`.
  - Each shift increments `bit_cnt`, which saturates at 127.
- **Ignored edges:** clock edges while CS is high or while not armed are ignored.
- **On synchronized CS rising edge while armed:** clear armed.
  - If `bit_cnt` == 16*`N_DEV`: latch all devices and pulse `update`.
  - Otherwise: pulse `frame_err` and change no registers.
- **Device numbering:** device k takes frame `sr[16k+:16]`. k = `N_DEV`-1 is the first frame transmitted (farthest device); k = 0 is the last.
- **Frame decoding:** addr = `frame[11:8]`, dat = `frame[7:0]`; `frame[15:12]` is ignored.
  - 0x0: no-op.
  - 0x1–0x8, digit row r = addr: `image[64N-8N*r+8k +: 8]` ← dat.
  - 0x9: `decode_mode` ← dat.
  - 0xA: `intensity` ← `dat[3:0]`.
  - 0xB: `scan_limit` ← `dat[2:0]`.
  - 0xC: `shutdown_n` ← `dat[0]`.
  - 0xF: `test` ← `dat[0]`.
  - 0xD, 0xE: ignored.
- **No digit decode:** digit bytes are stored raw regardless of `decode_mode`.
- **Image layout:** row 1, device `N_DEV`-1 lands in `image[64N-1 -: 8]`. For N=4 this is `[255:248]`, i.e. the 256-bit image equals the parallel data handed to the LED driver.

## Timing
- **Reset values:** all outputs 0, including `shutdown_n` = 0. Synchronizers reset to CS = 1 and CLK = 0. `sr` and `bit_cnt` reset to 0; armed is cleared.
- **Shift latency:** a serial edge is acted on at the 3rd `clk` edge after it is first sampled.
- **Latch latency:** registers and `update`/`frame_err` change at the 3rd `clk` edge after the first `clk` edge that samples `leds_cs_in` high.
- **Simultaneous edges:** when a CLK rise and a CS rise are detected in the same cycle, the CS rise wins and no shift occurs.
- **Reset mid-frame:** discards the partial frame. Bits arriving before the next CS fall are ignored.
- **`leds_out`:** follows `sr` MSB combinationally from the register, with no extra delay.

## Structure
- **Package `led7219_pkg`:**
  - Register address constants: `REG_NOOP`, `REG_DIGIT0`..`REG_DIGIT7` (1–8), `REG_DECODE`, `REG_INTENSITY`, `REG_SCAN`, `REG_SHUTDOWN`, `REG_TEST`.
  - `FRAME_W` = 16.
- **Sub-module `led_sync`:** 2-FF synchronizer plus edge-detect register, with rise and fall outputs. It is instantiated three times.

## Test plan
- **Scan-limit broadcast:** after reset, send 64'h0b07_0b07_0b07_0b07 → `scan_limit` = 12'o7777, one `update` pulse, `image` still 0.
- **Single row:** send 64'h01A5_015A_01FF_0101 → `image[255:224]` = 32'hA55AFF01, all other image bits 0.
- **Full driver sequence:** run the full 12-frame driver sequence with data 256'h0123…EF (repeating) → `image` equals the data after the 12th frame. Also `intensity` = 16'h7777, `shutdown_n` = 4'hF, `test` = 0, and 12 `update` pulses in total.
- **Per-device mixed frame:** send 64'h0c01_0000_0c00_0f01 after all-normal → `shutdown_n` = 4'b1101, `test` = 4'b0001, device 2 unchanged.
- **Short frame:** raise CS after 40 clocks → exactly one `frame_err` pulse, no register change. A following 64-bit frame is accepted normally.
- **Reset mid-frame:** assert `rst` for 1 cycle after 30 bits → all outputs 0. The remaining 34 clocks and the CS rise produce neither `update` nor `frame_err`, and the next full frame is accepted.
